scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
- Issue controller for the decode stage and its 16-entry register file.
- Tracks in-flight register writers and a pending status-register update with per-register counters.
- Drives the ID-stage `hazard` (stall) input; also folds in the memory freeze.
- Sits beside the ID stage; fed by ID decode fields, the EXE status update and WB write-back.

Parameters:
- CNT_W, 2, width of each pending-writer counter; max in-flight writers per register = 2^CNT_W-1.
- NREG, 16, number of architectural registers tracked.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- id_valid  input  1  ID holds a real (non-bubble) instruction
- id_cond  input  4  instruction[31:28]
- src1  input  4  Rn index
- src1_used  input  1  instruction reads Rn
- src2  input  4  second source index (Rm, or Rd for stores)
- two_src  input  1  instruction reads src2
- id_dest  input  4  Rd
- id_wb_en  input  1  undimmed controller wb_en
- id_s  input  1  undimmed controller S bit
- flush  input  1  taken branch in EXE; the ID instruction is squashed
- sr_update  input  1  one-cycle pulse: EXE wrote the SR
- wb_wb_en  input  1  WB stage writes register file this cycle
- wb_dest  input  4  WB destination
- mem_freeze  input  1  memory not ready; whole pipeline holds
- hazard  output  1  stall ID/IF this cycle
- pending_mask  output  NREG  bit i = counter i nonzero
- sr_pending  output  1  SR update in flight

Behaviour:
- Counter state: cnt[0..NREG-1] (CNT_W bits each) and sr_cnt (CNT_W bits).
- Reset: all counters 0. With counters at 0, hazard = mem_freeze, pending_mask = 0, sr_pending = 0.
- hazard is combinational: mem_freeze OR (id_valid AND any of the following):
  - src1_used & cnt[src1]!=0
  - two_src & cnt[src2]!=0
  - id_wb_en & cnt[id_dest]==max (WAW overflow)
  - id_cond!=AL(4'b1110) & sr_cnt!=0
  - id_s & sr_cnt==max
- issue = id_valid & ~hazard & ~flush.
  - issue & id_wb_en increments cnt[id_dest].
  - issue & id_s increments sr_cnt.
- Condition-failed instructions still issue and count:
  - Their WB stage deasserts wb_en, so the counter would never retire.
  - Therefore the caller passes id_wb_en/id_s gated by the condition check. Callers guarantee this.
- Retire is gated by ~mem_freeze, so a held WB is not counted twice:
  - wb_wb_en & ~mem_freeze decrements cnt[wb_dest].
  - sr_update & ~mem_freeze decrements sr_cnt.
- Same-cycle increment and decrement of the same counter leaves it unchanged.
- Decrement at 0 is a protocol error:
  - Counter stays 0.
  - Simulation-only $error.
- Increment at max cannot occur: hazard blocks it.
- flush takes priority over issue; counters from earlier instructions are untouched.
- Reset mid-operation clears all counters asynchronously.
  - The caller resets pipeline registers on the same rst.
- Latency: a writer issued in cycle t makes the register pending from t+1. A retire in cycle t clears it from t+1.
  - Register-file writes occur on negedge, so the next-cycle read is correct with no extra bubble.
- R15 is tracked like any other register.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output `stall_cycles` (32 bits): count of cycles with id_valid & hazard & ~mem_freeze.
  - Adds output `freeze_cycles` (32 bits): count of cycles with mem_freeze.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file holds:
  - condition code AL
  - NREG default
  - CNT_W default
- One natural sub-module: `sb_counter` (inc, dec, cnt, full, nonzero, saturation-safe).
  - Instantiate it NREG+1 times: NREG register counters plus one SR counter.

Test Plan:
1. Reset with rst=1 mid-stream, counters loaded -> next cycle pending_mask=0, sr_pending=0, hazard=0 (mem_freeze=0).
2. Producer-consumer: issue ADD R3 (wb_en) at t0; ID at t1 = SUB src1=R3 -> hazard=1 at t1 and t2. WB retire R3 at t3 -> hazard=0 at t4, pending_mask[3]=0.
3. WAW overflow, CNT_W=2: three writers to R5 with no retires -> cnt[5]=3; fourth writer to R5 -> hazard=1 until a retire of R5 is seen.
4. Same-cycle events: issue writer R7 and retire R7 together with cnt[7]=1 -> cnt[7] stays 1, pending_mask[7]=1.
5. SR hazard: issue CMP (id_s=1) then BEQ (id_cond=0000) -> hazard=1 until the sr_update pulse. BAL (1110) in the same situation -> hazard=0.
6. Freeze and flush:
   - mem_freeze=1 for 3 cycles with wb_wb_en=1 held -> cnt decremented exactly once, after the freeze drops.
   - flush=1 with a writer in ID -> no increment.
   - With HAZARD_STATS_EN: freeze_cycles=3.

Source files
------------

// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared definitions for the decode-stage scoreboard: condition codes and
// default sizing of the pending-writer counters.
package scoreboard_hazard_unit_pkg;

  // Condition field value meaning "always execute".
  localparam logic [3:0] COND_AL   = 4'b1110;
  // Architectural registers tracked by default.
  localparam int         NREG_DEF  = 16;
  // Default width of each pending-writer counter.
  localparam int         CNT_W_DEF = 2;

  // True when an instruction's condition field does not depend on flags.
  function automatic logic cond_is_al(input logic [3:0] cond);
    return (cond == COND_AL);
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_sb_counter.sv
// Saturation-safe pending-writer counter used once per register and once
// for the status register. Increment and decrement in the same cycle
// cancel. A decrement at zero holds the count at zero and, in simulation,
// is reported by sb_counter_chk. An increment at full is blocked upstream
// by the hazard logic and is also ignored here.
import scoreboard_hazard_unit_pkg::*;

module sb_counter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count: single inc or dec moves the count, clamped at both ends.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({inc, dec})
      2'b10: begin
        if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_ONE;
        else                  cnt_nxt_s = cnt_r;
      end
      2'b01: begin
        if (cnt_r != CNT_ZERO) cnt_nxt_s = cnt_r - CNT_ONE;
        else                   cnt_nxt_s = cnt_r;
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_r <= CNT_ZERO;
    else     cnt_r <= cnt_nxt_s;
  end

  assign full    = (cnt_r == CNT_MAX);
  assign nonzero = (cnt_r != CNT_ZERO);

`ifndef SYNTHESIS
  sb_counter_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .nonzero (nonzero)
  );
`endif

endmodule

// Simulation-only protocol checker: a retire with nothing pending means the
// caller lost track of an in-flight writer.
module sb_counter_chk (
  input logic clk,
  input logic rst,
  input logic inc,
  input logic dec,
  input logic nonzero
);

  // Flag a lone decrement of an empty counter.
  always @(posedge clk) begin
    if (!rst && dec && !inc && !nonzero)
      $error("sb_counter: retire with no pending writer");
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-stage issue controller. Tracks in-flight register writers and a
// pending status-register update with per-register counters, and drives the
// ID-stage stall. Optional macro HAZARD_STATS_EN adds stall/freeze cycle
// counters on two extra 32-bit outputs.
import scoreboard_hazard_unit_pkg::*;

module scoreboard_hazard_unit #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [3:0]      id_cond,
  input  logic [3:0]      src1,
  input  logic            src1_used,
  input  logic [3:0]      src2,
  input  logic            two_src,
  input  logic [3:0]      id_dest,
  input  logic            id_wb_en,
  input  logic            id_s,
  input  logic            flush,
  input  logic            sr_update,
  input  logic            wb_wb_en,
  input  logic [3:0]      wb_dest,
  input  logic            mem_freeze,
  output logic            hazard,
  output logic [NREG-1:0] pending_mask,
  output logic            sr_pending
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     freeze_cycles
`endif
);

  logic [NREG-1:0] nonzero_s;
  logic [NREG-1:0] full_s;
  logic            sr_nonzero_s;
  logic            sr_full_s;
  logic            dep_s;
  logic            issue_s;
  logic            retire_s;
  logic            sr_retire_s;

  // Dependency check on the ID instruction: RAW on either source, WAW
  // overflow on the destination, flag read while SR update is in flight,
  // and SR counter overflow.
  always_comb begin
    dep_s = 1'b0;
    if (id_valid) begin
      dep_s = (src1_used & nonzero_s[src1])
            | (two_src   & nonzero_s[src2])
            | (id_wb_en  & full_s[id_dest])
            | (~cond_is_al(id_cond) & sr_nonzero_s)
            | (id_s      & sr_full_s);
    end else begin
      dep_s = 1'b0;
    end
  end

  assign hazard      = mem_freeze | dep_s;
  // Flush wins over issue: a squashed instruction never claims a counter.
  assign issue_s     = id_valid & ~hazard & ~flush;
  // A WB held by the freeze must be counted only once, after it releases.
  assign retire_s    = wb_wb_en  & ~mem_freeze;
  assign sr_retire_s = sr_update & ~mem_freeze;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (issue_s  & id_wb_en & (id_dest == 4'(i))),
      .dec     (retire_s & (wb_dest == 4'(i))),
      .full    (full_s[i]),
      .nonzero (nonzero_s[i])
    );
  end

  sb_counter #(.CNT_W(CNT_W)) u_sr_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (issue_s & id_s),
    .dec     (sr_retire_s),
    .full    (sr_full_s),
    .nonzero (sr_nonzero_s)
  );

  assign pending_mask = nonzero_s;
  assign sr_pending   = sr_nonzero_s;

`ifdef HAZARD_STATS_EN
  // Free-running, wrapping counts of dependency stalls and memory freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= 32'd0;
      freeze_cycles <= 32'd0;
    end else begin
      if (id_valid & hazard & ~mem_freeze) stall_cycles <= stall_cycles + 32'd1;
      else                                 stall_cycles <= stall_cycles;
      if (mem_freeze) freeze_cycles <= freeze_cycles + 32'd1;
      else            freeze_cycles <= freeze_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed self-checking bench for scoreboard_hazard_unit (default sizing:
// 16 registers, 2-bit counters). Inputs change 1 time unit after a rising
// edge; outputs are checked 1 more unit later, well away from the edge.
module tb_scoreboard_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_cond;
  logic [3:0]  src1;
  logic        src1_used;
  logic [3:0]  src2;
  logic        two_src;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_s;
  logic        flush;
  logic        sr_update;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic        mem_freeze;
  logic        hazard;
  logic [15:0] pending_mask;
  logic        sr_pending;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] freeze_cycles;
`endif

  int checks_n = 0;
  int fails_n  = 0;

  scoreboard_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_cond      (id_cond),
    .src1         (src1),
    .src1_used    (src1_used),
    .src2         (src2),
    .two_src      (two_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_s         (id_s),
    .flush        (flush),
    .sr_update    (sr_update),
    .wb_wb_en     (wb_wb_en),
    .wb_dest      (wb_dest),
    .mem_freeze   (mem_freeze),
    .hazard       (hazard),
    .pending_mask (pending_mask),
    .sr_pending   (sr_pending)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .freeze_cycles(freeze_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      fails_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_cond = 4'b1110; src1 = 4'd0; src1_used = 1'b0;
    src2 = 4'd0; two_src = 1'b0; id_dest = 4'd0; id_wb_en = 1'b0; id_s = 1'b0;
    flush = 1'b0; sr_update = 1'b0; wb_wb_en = 1'b0; wb_dest = 4'd0;
    mem_freeze = 1'b0;
  endtask

  // Advance one cycle: inputs set before the call are sampled at this edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ID holds a writer of dest (no sources).
  task automatic writer(input logic [3:0] dest);
    idle();
    id_valid = 1'b1; id_wb_en = 1'b1; id_dest = dest;
  endtask

  // Retire dest through WB with nothing in ID.
  task automatic retire(input logic [3:0] dest);
    idle();
    wb_wb_en = 1'b1; wb_dest = dest;
  endtask

  initial begin
    // ---- 1: reset, then reset mid-stream with counters loaded ----
    idle();
    rst = 1'b1;
    repeat (2) step();
    #1;
    check("rst_mask",   32'(pending_mask), 32'h0);
    check("rst_sr",     32'(sr_pending),   32'h0);
    check("rst_hazard", 32'(hazard),       32'h0);
    rst = 1'b0;
    step();
    writer(4'd1); id_s = 1'b1;
    step();
    idle(); #1;
    check("load_mask", 32'(pending_mask), 32'h0002);
    check("load_sr",   32'(sr_pending),   32'h1);
    rst = 1'b1; #2; rst = 1'b0;
    id_valid = 1'b1; id_cond = 4'b0000; src1_used = 1'b1; src1 = 4'd1; #1;
    check("midrst_mask",   32'(pending_mask), 32'h0);
    check("midrst_sr",     32'(sr_pending),   32'h0);
    check("midrst_hazard", 32'(hazard),       32'h0);
    step();

    // ---- 2: producer / consumer on R3 ----
    writer(4'd3); #1;
    check("pc_t0_hazard", 32'(hazard), 32'h0);
    step();
    writer(4'd4); src1_used = 1'b1; src1 = 4'd3; #1;
    check("pc_t1_hazard", 32'(hazard), 32'h1);
    step(); #1;
    check("pc_t2_hazard", 32'(hazard), 32'h1);
    step();
    wb_wb_en = 1'b1; wb_dest = 4'd3; #1;
    check("pc_t3_hazard", 32'(hazard), 32'h1);
    step();
    wb_wb_en = 1'b0; #1;
    check("pc_t4_hazard", 32'(hazard), 32'h0);
    check("pc_t4_mask3",  32'(pending_mask[3]), 32'h0);
    step();  // SUB issues, R4 pending
    retire(4'd4);
    step();
    idle(); #1;
    check("pc_drain_mask", 32'(pending_mask), 32'h0);

    // ---- 3: WAW overflow on R5 ----
    for (int k = 0; k < 3; k++) begin
      writer(4'd5); #1;
      check("waw_fill_hazard", 32'(hazard), 32'h0);
      step();
    end
    writer(4'd5); #1;
    check("waw_full_hazard", 32'(hazard), 32'h1);
    step(); #1;
    check("waw_hold_hazard", 32'(hazard), 32'h1);
    wb_wb_en = 1'b1; wb_dest = 4'd5; #1;
    check("waw_ret_hazard", 32'(hazard), 32'h1);
    step();
    wb_wb_en = 1'b0; #1;
    check("waw_free_hazard", 32'(hazard), 32'h0);
    step();  // fourth writer issues, count back to 3
    for (int k = 0; k < 3; k++) begin
      retire(4'd5);
      step();
    end
    idle(); #1;
    check("waw_drain_mask", 32'(pending_mask), 32'h0);

    // ---- 4: same-cycle issue and retire on R7 ----
    writer(4'd7);
    step();
    writer(4'd7); wb_wb_en = 1'b1; wb_dest = 4'd7;
    step();
    idle(); #1;
    check("same_mask", 32'(pending_mask), 32'h0080);
    retire(4'd7);
    step();
    idle(); #1;
    check("same_drain_mask", 32'(pending_mask), 32'h0);

    // ---- 5: SR hazard ----
    idle(); id_valid = 1'b1; id_s = 1'b1;  // CMP
    step();
    idle(); id_valid = 1'b1; id_cond = 4'b0000; #1;  // BEQ
    check("sr_pend",     32'(sr_pending), 32'h1);
    check("beq_hazard1", 32'(hazard),     32'h1);
    step(); #1;
    check("beq_hazard2", 32'(hazard), 32'h1);
    sr_update = 1'b1; #1;
    check("beq_hazard3", 32'(hazard), 32'h1);
    step();
    sr_update = 1'b0; #1;
    check("beq_free_hazard", 32'(hazard),     32'h0);
    check("beq_free_sr",     32'(sr_pending), 32'h0);
    step();
    idle(); id_valid = 1'b1; id_s = 1'b1;  // CMP
    step();
    idle(); id_valid = 1'b1; id_cond = 4'b1110; #1;  // BAL
    check("bal_hazard", 32'(hazard), 32'h0);
    step();
    idle(); sr_update = 1'b1;
    step();
    idle(); #1;
    check("bal_drain_sr", 32'(sr_pending), 32'h0);

    // ---- R15 read through src2 ----
    writer(4'd15);
    step();
    idle(); id_valid = 1'b1; two_src = 1'b1; src2 = 4'd15; #1;
    check("r15_hazard", 32'(hazard), 32'h1);
    id_valid = 1'b0; #1;
    check("bubble_hazard", 32'(hazard), 32'h0);
    retire(4'd15);
    step();
    idle(); #1;
    check("r15_drain_mask", 32'(pending_mask), 32'h0);

    // ---- 6: freeze with WB held, then flush ----
    writer(4'd9);
    step();
    idle(); mem_freeze = 1'b1; wb_wb_en = 1'b1; wb_dest = 4'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("frz_hazard", 32'(hazard),       32'h1);
      check("frz_mask",   32'(pending_mask), 32'h0200);
      step();
    end
    mem_freeze = 1'b0; #1;
    check("frz_release_mask", 32'(pending_mask), 32'h0200);
    step();
    idle(); #1;
    check("frz_done_mask", 32'(pending_mask), 32'h0);
    writer(4'd10); flush = 1'b1;
    step();
    idle(); #1;
    check("flush_mask", 32'(pending_mask), 32'h0);
`ifdef HAZARD_STATS_EN
    check("freeze_cycles", freeze_cycles, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
